// File: rtl/wir_load_sequencer.sv
// IEEE 1500 WIR load sequencer: capture (optional), shift opcode
// LSB first, update, then a one-cycle done pulse with readback.
module wir_load_sequencer #(
  parameter int WIR_LEN = 12
) (
  input  logic               CLK,
  input  logic               WRST,
  input  logic               req,
  input  logic [WIR_LEN-1:0] instr,
  input  logic               capture_en,
  input  logic               abort,
  input  logic               wir_so,
  output logic               wir_si,
  output logic               wir_capture,
  output logic               wir_shift,
  output logic               wir_update,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic [WIR_LEN-1:0] readback
);

  localparam int CW = $clog2(WIR_LEN) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIR_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    SHIFT,
    UPDATE,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [WIR_LEN-1:0] sh_q, sh_d;
  logic [WIR_LEN-1:0] rb_q, rb_d;
  logic [WIR_LEN-1:0] rbk_q, rbk_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               ab_q, ab_d;

  // State and datapath registers, synchronous reset
  always_ff @(posedge CLK) begin
    if (WRST) begin
      state_q <= IDLE;
      sh_q    <= '0;
      rb_q    <= '0;
      rbk_q   <= '0;
      cnt_q   <= '0;
      ab_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      rb_q    <= rb_d;
      rbk_q   <= rbk_d;
      cnt_q   <= cnt_d;
      ab_q    <= ab_d;
    end
  end

  // Next-state and datapath update; abort beats req, commits after SHIFT
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    rb_d    = rb_q;
    rbk_d   = rbk_q;
    cnt_d   = cnt_q;
    ab_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req && !abort) begin
          sh_d    = instr;
          cnt_d   = '0;
          state_d = capture_en ? CAPTURE : SHIFT;
        end
      end
      CAPTURE: begin
        if (abort) begin
          state_d = IDLE;
          ab_d    = 1'b1;
        end else begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
          ab_d    = 1'b1;
        end else begin
          sh_d  = {1'b0, sh_q[WIR_LEN-1:1]};
          rb_d  = {wir_so, rb_q[WIR_LEN-1:1]};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = UPDATE;
        end
      end
      UPDATE: begin
        rbk_d   = rb_q;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes decoded from registered state only
  always_comb begin
    wir_si      = sh_q[0];
    wir_capture = (state_q == CAPTURE);
    wir_shift   = (state_q == SHIFT);
    wir_update  = (state_q == UPDATE);
    busy        = (state_q != IDLE);
    done        = (state_q == DONE);
    aborted     = ab_q;
    readback    = rbk_q;
  end

endmodule

// File: tb/tb_wir_load_sequencer.sv
// Directed bench for wir_load_sequencer with a behavioural WIR
// model on the serial side.
module tb_wir_load_sequencer;

  logic        CLK = 1'b0;
  logic        WRST = 1'b1;
  logic        req = 1'b0;
  logic [11:0] instr = '0;
  logic        capture_en = 1'b0;
  logic        abort = 1'b0;
  logic        wir_so;
  logic        wir_si, wir_capture, wir_shift, wir_update;
  logic        busy, done, aborted;
  logic [11:0] readback;

  int n_chk = 0;
  int n_fail = 0;

  logic [11:0] wir_sr    = '0;
  logic [11:0] wir_instr = '0;
  logic [11:0] cap_val   = 12'hA5C;
  int          upd_cnt   = 0;

  wir_load_sequencer #(.WIR_LEN(12)) dut (
    .CLK(CLK), .WRST(WRST), .req(req), .instr(instr),
    .capture_en(capture_en), .abort(abort), .wir_so(wir_so),
    .wir_si(wir_si), .wir_capture(wir_capture),
    .wir_shift(wir_shift), .wir_update(wir_update),
    .busy(busy), .done(done), .aborted(aborted),
    .readback(readback)
  );

  always #5 CLK = ~CLK;

  // Behavioural WIR: capture loads cap_val, shift in at MSB
  assign wir_so = wir_sr[0];
  always @(posedge CLK) begin
    if (wir_capture) wir_sr <= cap_val;
    else if (wir_shift) wir_sr <= {wir_si, wir_sr[11:1]};
    if (wir_update) begin
      wir_instr <= wir_sr;
      upd_cnt   <= upd_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_load(input logic [11:0] ins,
                         input logic cap,
                         input logic [11:0] exp_rb);
    logic [11:0] v;
    v = ins;
    req = 1'b1; instr = ins; capture_en = cap;
    tick();
    req = 1'b0;
    if (cap) begin
      check("capture", 32'(wir_capture), 32'd1);
      tick();
    end
    for (int i = 0; i < 12; i++) begin
      check("shift", 32'(wir_shift), 32'd1);
      check("si", 32'(wir_si), 32'(v[i]));
      tick();
    end
    check("update", 32'(wir_update), 32'd1);
    check("no_done_early", 32'(done), 32'd0);
    tick();
    check("done", 32'(done), 32'd1);
    check("readback", 32'(readback), 32'(exp_rb));
    tick();
    check("idle_busy", 32'(busy), 32'd0);
    check("done_pulse", 32'(done), 32'd0);
  endtask

  initial begin
    int u0;
    int n;

    // 1. reset
    tick(); tick();
    check("rst_outs",
          32'({wir_si, wir_capture, wir_shift, wir_update,
               busy, done, aborted}), 32'd0);
    check("rst_rb", 32'(readback), 32'd0);
    WRST = 1'b0;
    tick();

    // 2. plain load, WIR shift register starts at 0
    do_load(12'b010010010010, 1'b0, 12'h000);
    check("wir_instr2", 32'(wir_instr), 32'h492);

    // 3. capture then load
    do_load(12'h3C1, 1'b1, 12'hA5C);
    check("wir_instr3", 32'(wir_instr), 32'h3C1);

    // abort with req in IDLE: abort wins, nothing starts
    req = 1'b1; abort = 1'b1; instr = 12'h111;
    tick();
    req = 1'b0; abort = 1'b0;
    check("abort_idle_busy", 32'(busy), 32'd0);
    check("abort_idle_pulse", 32'(aborted), 32'd0);

    // 4. abort after the 5th shift cycle
    u0 = upd_cnt;
    req = 1'b1; instr = 12'hFFF; capture_en = 1'b0;
    tick();
    req = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("shift6", 32'(wir_shift), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("aborted", 32'(aborted), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    tick();
    check("aborted_pulse", 32'(aborted), 32'd0);
    check("abort_no_upd", 32'(upd_cnt), 32'(u0));
    check("abort_keep", 32'(wir_instr), 32'h3C1);

    // 5. req held through a load
    req = 1'b1; instr = 12'h1E7; capture_en = 1'b0;
    tick();
    n = 1;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    check("held_done_lat", 32'(n), 32'd14);
    tick();
    check("gap_busy", 32'(busy), 32'd0);
    check("gap_shift", 32'(wir_shift), 32'd0);
    tick();
    req = 1'b0;
    check("second_shift", 32'(wir_shift), 32'd1);
    check("wir_instr5", 32'(wir_instr), 32'h1E7);
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    check("second_done_lat", 32'(n), 32'd13);
    tick();

    // 6. reset mid-shift, then a fresh load
    u0 = upd_cnt;
    req = 1'b1; instr = 12'h555; capture_en = 1'b1;
    tick();
    req = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("pre_rst_shift", 32'(wir_shift), 32'd1);
    WRST = 1'b1;
    tick();
    WRST = 1'b0;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_shift", 32'(wir_shift), 32'd0);
    tick();
    check("rst_mid_pulses",
          32'({wir_update, done, aborted}), 32'd0);
    check("rst_mid_no_upd", 32'(upd_cnt), 32'(u0));
    do_load(12'h0F0, 1'b1, 12'hA5C);
    check("wir_instr6", 32'(wir_instr), 32'h0F0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
